z80_rom_wait_ctrl: RTL and testbench



---
 rtl/z80_rom_wait_ctrl_if.sv | 67 ++++++
 rtl/z80_rom_wait_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_z80_rom_wait_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/z80_rom_wait_ctrl_if.sv
// ---------------------------------------------------------------------------
// z80_rom_wait_ctrl_if
//
// Bundles the Z80 (T80s) bus signals and the external ROM request/acknowledge
// port that the ROM wait-state controller sits between.
//
//   Z80 side
//     SDA       [15:0]  address bus
//     nMREQ             memory request, refresh already masked, active low
//     nIORQ             I/O request, active low
//     nRD               read strobe, active low
//     nWAIT             to Z80 WAIT_n; low stalls the CPU
//     SDD_ROM   [7:0]   ROM read data toward the Z80 data-in mux
//     ROM_SEL           high while the current memory read targets ROM
//   External memory side
//     ROM_REQ           level request, high until acknowledged
//     ROM_ADDR  [ADDR_W-1:0] byte address, stable while ROM_REQ is high
//     ROM_ACK           one-cycle acknowledge, ROM_DATA valid in same cycle
//     ROM_DATA  [7:0]   read byte
//
// Modports
//   slave  : the controller itself
//   master : everything around it (CPU core plus memory arbiter)
// ---------------------------------------------------------------------------
interface z80_rom_wait_ctrl_if #(
    parameter int ADDR_W = 22
);
    logic [15:0]       SDA;
    logic              nMREQ;
    logic              nIORQ;
    logic              nRD;
    logic              nWAIT;
    logic [7:0]        SDD_ROM;
    logic              ROM_SEL;
    logic              ROM_REQ;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic              ROM_ACK;
    logic [7:0]        ROM_DATA;

    modport slave (
        input  SDA,
        input  nMREQ,
        input  nIORQ,
        input  nRD,
        input  ROM_ACK,
        input  ROM_DATA,
        output nWAIT,
        output SDD_ROM,
        output ROM_SEL,
        output ROM_REQ,
        output ROM_ADDR
    );

    modport master (
        output SDA,
        output nMREQ,
        output nIORQ,
        output nRD,
        output ROM_ACK,
        output ROM_DATA,
        input  nWAIT,
        input  SDD_ROM,
        input  ROM_SEL,
        input  ROM_REQ,
        input  ROM_ADDR
    );
endinterface

// File: rtl/z80_rom_wait_ctrl.sv
// ---------------------------------------------------------------------------
// z80_rom_wait_ctrl
//
// Turns Z80 sound-CPU memory reads into request/acknowledge transactions on
// the external ROM port and stalls the CPU with WAIT_n until the byte is back.
// Also decodes the M1 memory map and holds the four NeoGeo M1 bank registers,
// which the CPU loads with IN instructions (port in SDA[3:0], value SDA[15:8]).
//
// Ports
//   CLK     system clock; the Z80 runs from it through a clock enable
//   RESET   asynchronous, active high; returns everything to reset values
//   bus     z80_rom_wait_ctrl_if.slave (Z80 bus + external ROM port)
//
// Memory map (by SDA)
//   0000-7FFF  fixed           {0, SDA[14:0]}
//   8000-BFFF  bank0 (16 KB)   bank0*16K + SDA[13:0]
//   C000-DFFF  bank1 ( 8 KB)   bank1*8K  + SDA[12:0]
//   E000-EFFF  bank2 ( 4 KB)   bank2*4K  + SDA[11:0]
//   F000-F7FF  bank3 ( 2 KB)   bank3*2K  + SDA[10:0]
//   F800-FFFF  work RAM, handled elsewhere (no request, no wait)
// ---------------------------------------------------------------------------
module z80_rom_wait_ctrl #(
    parameter int ADDR_W = 22
) (
    input  logic               CLK,
    input  logic               RESET,
    z80_rom_wait_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reset values give a linear map of 0000-F7FF.
    localparam logic [7:0] BANK0_RST = 8'h02;
    localparam logic [7:0] BANK1_RST = 8'h06;
    localparam logic [7:0] BANK2_RST = 8'h0E;
    localparam logic [7:0] BANK3_RST = 8'h1E;

    state_t            state_q;
    logic              rom_req_q;
    logic              rom_sel_q;
    logic [7:0]        sdd_rom_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] rom_addr_d;

    logic [7:0]        bank0_q;
    logic [7:0]        bank1_q;
    logic [7:0]        bank2_q;
    logic [7:0]        bank3_q;

    // Registered copies of the combined strobes, used for falling-edge
    // detection. Both idle high.
    logic              mem_strobe_n;
    logic              mem_strobe_q;
    logic              io_strobe_n;
    logic              io_strobe_q;

    logic              rom_space;
    logic              start;
    logic              io_fall;

    // -----------------------------------------------------------------------
    // ROM byte address for a CPU address under the current bank settings.
    // Arithmetic is done wide and truncated, so an oversized bank wraps.
    // -----------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] rom_addr_f(
        input logic [15:0] a,
        input logic [7:0]  b0,
        input logic [7:0]  b1,
        input logic [7:0]  b2,
        input logic [7:0]  b3
    );
        logic [31:0] full;
        if (!a[15]) begin
            full = {17'd0, a[14:0]};
        end else if (!a[14]) begin
            full = {10'd0, b0, 14'd0} + {18'd0, a[13:0]};
        end else if (!a[13]) begin
            full = {11'd0, b1, 13'd0} + {19'd0, a[12:0]};
        end else if (!a[12]) begin
            full = {12'd0, b2, 12'd0} + {20'd0, a[11:0]};
        end else begin
            full = {13'd0, b3, 11'd0} + {21'd0, a[10:0]};
        end
        return ADDR_W'(full);
    endfunction

    assign mem_strobe_n = bus.nMREQ | bus.nRD;
    assign io_strobe_n  = bus.nIORQ | bus.nRD;
    assign rom_space    = (bus.SDA < 16'hF800);

    // A read is new only if the strobe was high in the previous cycle, so a
    // long read held across DONE->IDLE cannot start a second transaction.
    assign start   = (state_q == ST_IDLE) && !mem_strobe_n && mem_strobe_q && rom_space;
    assign io_fall = io_strobe_q && !io_strobe_n;

    assign rom_addr_d = rom_addr_f(bus.SDA, bank0_q, bank1_q, bank2_q, bank3_q);

    // nWAIT is combinational so the CPU is already stalled in the first cycle
    // of the read, ahead of its WAIT sample point.
    assign bus.nWAIT    = !(start || (state_q == ST_REQ));
    assign bus.ROM_REQ  = rom_req_q;
    assign bus.ROM_ADDR = rom_addr_q;
    assign bus.ROM_SEL  = rom_sel_q;
    assign bus.SDD_ROM  = sdd_rom_q;

    // -----------------------------------------------------------------------
    // Bank registers, loaded on the falling edge of IORQ&RD. Only SDA[3:0]
    // selects the port; SDA[7:4] is deliberately not decoded.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            io_strobe_q <= 1'b1;
            bank0_q     <= BANK0_RST;
            bank1_q     <= BANK1_RST;
            bank2_q     <= BANK2_RST;
            bank3_q     <= BANK3_RST;
        end else begin
            io_strobe_q <= io_strobe_n;
            if (io_fall) begin
                case (bus.SDA[3:0])
                    4'hB:    bank0_q <= bus.SDA[15:8];
                    4'hA:    bank1_q <= bus.SDA[15:8];
                    4'h9:    bank2_q <= bus.SDA[15:8];
                    4'h8:    bank3_q <= bus.SDA[15:8];
                    default: ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transaction FSM with registered outputs. An asynchronous reset drops
    // ROM_REQ immediately; an acknowledge outside REQ is simply not looked at.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            mem_strobe_q <= 1'b1;
            rom_req_q    <= 1'b0;
            rom_sel_q    <= 1'b0;
            sdd_rom_q    <= 8'h00;
            rom_addr_q   <= '0;
        end else begin
            mem_strobe_q <= mem_strobe_n;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rom_addr_q <= rom_addr_d;
                        rom_req_q  <= 1'b1;
                        rom_sel_q  <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.ROM_ACK) begin
                        sdd_rom_q <= bus.ROM_DATA;
                        rom_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Hold the data on the mux until the CPU ends the cycle.
                    if (mem_strobe_n) begin
                        rom_sel_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    rom_req_q <= 1'b0;
                    rom_sel_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_rom_wait_ctrl.sv
// ---------------------------------------------------------------------------
// tb_z80_rom_wait_ctrl
//
// Directed bench for z80_rom_wait_ctrl. Inputs change on the falling clock
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_z80_rom_wait_ctrl;

    localparam int ADDR_W = 22;

    logic clk;
    logic rst;

    int n_vec;
    int n_err;
    int req_rises;

    z80_rom_wait_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    z80_rom_wait_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge bus.ROM_REQ) req_rises++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One Z80 memory read. ROM_ACK is given on the ack_n-th cycle that
    // ROM_REQ is high. Returns the number of cycles nWAIT was low and the
    // address seen while the request was up. Leaves the strobes released.
    task automatic do_read(input logic [15:0] a, input logic [7:0] d, input int ack_n,
                           output int waits, output logic [ADDR_W-1:0] addr_seen);
        int  reqc;
        bit  done;
        waits     = 0;
        reqc      = 0;
        done      = 1'b0;
        addr_seen = '0;
        @(negedge clk);
        bus.SDA   = a;
        bus.nMREQ = 1'b0;
        bus.nRD   = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            bus.ROM_ACK = 1'b0;
            if (bus.ROM_REQ) begin
                reqc++;
                addr_seen    = bus.ROM_ADDR;
                bus.ROM_DATA = d;
                bus.ROM_ACK  = (reqc == ack_n);
            end
            #1;
            if (!bus.nWAIT) waits++;
            else            done = 1'b1;
        end
        chk("rd_released", 32'(done), 32'd1);
        bus.ROM_ACK = 1'b0;
        bus.nMREQ   = 1'b1;
        bus.nRD     = 1'b1;
    endtask

    // IN instruction: one cycle of IORQ&RD with the given address.
    task automatic do_in(input logic [15:0] a);
        @(negedge clk);
        bus.SDA   = a;
        bus.nIORQ = 1'b0;
        bus.nRD   = 1'b0;
        @(negedge clk);
        bus.nIORQ = 1'b1;
        bus.nRD   = 1'b1;
    endtask

    initial begin
        int                waits;
        int                rises0;
        logic [ADDR_W-1:0] addr;

        n_vec     = 0;
        n_err     = 0;
        req_rises = 0;

        rst          = 1'b1;
        bus.SDA      = 16'h0000;
        bus.nMREQ    = 1'b1;
        bus.nIORQ    = 1'b1;
        bus.nRD      = 1'b1;
        bus.ROM_ACK  = 1'b0;
        bus.ROM_DATA = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_nwait",   32'(bus.nWAIT),    32'd1);
        chk("rst_req",     32'(bus.ROM_REQ),  32'd0);
        chk("rst_sel",     32'(bus.ROM_SEL),  32'd0);
        chk("rst_sdd",     32'(bus.SDD_ROM),  32'h00);
        chk("rst_addr",    32'(bus.ROM_ADDR), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed region, ack on the third REQ cycle: stall = start + 3 REQ.
        rises0 = req_rises;
        do_read(16'h1234, 8'hA5, 3, waits, addr);
        chk("r1234_addr",  32'(addr),         32'h001234);
        chk("r1234_wait",  32'(waits),        32'd4);
        chk("r1234_sdd",   32'(bus.SDD_ROM),  32'hA5);
        chk("r1234_sel",   32'(bus.ROM_SEL),  32'd1);
        chk("r1234_nreq",  32'(req_rises - rises0), 32'd1);
        @(negedge clk); #1;
        chk("r1234_selx",  32'(bus.ROM_SEL),  32'd0);

        // Fastest possible acknowledge: two stall cycles.
        do_read(16'h7FFF, 8'h5A, 1, waits, addr);
        chk("r7fff_addr",  32'(addr),         32'h007FFF);
        chk("r7fff_wait",  32'(waits),        32'd2);
        chk("r7fff_sdd",   32'(bus.SDD_ROM),  32'h5A);

        // Bank0 = 0x05, bank3 = 0xFF.
        do_in(16'h050B);
        do_read(16'h9001, 8'h11, 2, waits, addr);
        chk("b0_addr",     32'(addr),         32'h015001);
        do_in(16'hFF08);
        do_read(16'hF7FF, 8'h22, 1, waits, addr);
        chk("b3_addr",     32'(addr),         32'h07FFFF);
        chk("b3_sdd",      32'(bus.SDD_ROM),  32'h22);
        // Upper nibble of the port byte is not decoded: 0xFB selects bank0.
        do_in(16'h07FB);
        do_read(16'h8000, 8'h33, 1, waits, addr);
        chk("b0nib_addr",  32'(addr),         32'h01C000);
        // Bank1 and bank2.
        do_in(16'h100A);
        do_read(16'hC123, 8'h44, 1, waits, addr);
        chk("b1_addr",     32'(addr),         32'h020123);
        do_in(16'h2009);
        do_read(16'hEFFF, 8'h55, 1, waits, addr);
        chk("b2_addr",     32'(addr),         32'h020FFF);

        // Work RAM read: no request, no wait.
        rises0 = req_rises;
        do_read(16'hF900, 8'h66, 1, waits, addr);
        chk("ram_wait",    32'(waits),        32'd0);
        chk("ram_sel",     32'(bus.ROM_SEL),  32'd0);
        chk("ram_sdd",     32'(bus.SDD_ROM),  32'h55);

        // ROM write: ignored.
        @(negedge clk);
        bus.SDA   = 16'h1000;
        bus.nMREQ = 1'b0;
        bus.nRD   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("wr_nwait", 32'(bus.nWAIT),   32'd1);
            chk("wr_sel",   32'(bus.ROM_SEL), 32'd0);
        end
        bus.nMREQ = 1'b1;
        chk("ram_wr_nreq", 32'(req_rises - rises0), 32'd0);

        // Back-to-back reads with a single strobe-high cycle between.
        rises0 = req_rises;
        do_read(16'h0000, 8'hC1, 2, waits, addr);
        chk("bb0_addr",    32'(addr),         32'h000000);
        chk("bb0_sdd",     32'(bus.SDD_ROM),  32'hC1);
        do_read(16'h0001, 8'hC2, 1, waits, addr);
        chk("bb1_addr",    32'(addr),         32'h000001);
        chk("bb1_sdd",     32'(bus.SDD_ROM),  32'hC2);
        chk("bb_nreq",     32'(req_rises - rises0), 32'd2);

        // Acknowledge while idle is ignored.
        @(negedge clk);
        bus.ROM_DATA = 8'hEE;
        bus.ROM_ACK  = 1'b1;
        @(negedge clk);
        bus.ROM_ACK  = 1'b0;
        #1;
        chk("idleack_sdd", 32'(bus.SDD_ROM),  32'hC2);
        chk("idleack_req", 32'(bus.ROM_REQ),  32'd0);
        chk("idleack_sel", 32'(bus.ROM_SEL),  32'd0);

        // Reset in the middle of a request.
        @(negedge clk);
        bus.SDA   = 16'h8000;
        bus.nMREQ = 1'b0;
        bus.nRD   = 1'b0;
        @(negedge clk); #1;
        chk("mid_req",     32'(bus.ROM_REQ),  32'd1);
        rst = 1'b1;
        #1;
        chk("mid_req_drop", 32'(bus.ROM_REQ), 32'd0);
        chk("mid_sdd",     32'(bus.SDD_ROM),  32'h00);
        bus.nMREQ = 1'b1;
        bus.nRD   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.ROM_DATA = 8'h99;
        bus.ROM_ACK  = 1'b1;
        @(negedge clk);
        bus.ROM_ACK  = 1'b0;
        #1;
        chk("late_ack_sdd", 32'(bus.SDD_ROM), 32'h00);
        chk("late_ack_req", 32'(bus.ROM_REQ), 32'd0);

        // Banks are back at their linear reset mapping.
        do_read(16'hC000, 8'h3C, 1, waits, addr);
        chk("rst_b1_addr", 32'(addr),         32'h00C000);
        chk("rst_b1_sdd",  32'(bus.SDD_ROM),  32'h3C);
        do_read(16'h8000, 8'h3D, 1, waits, addr);
        chk("rst_b0_addr", 32'(addr),         32'h008000);
        do_read(16'hE800, 8'h3E, 1, waits, addr);
        chk("rst_b2_addr", 32'(addr),         32'h00E800);
        do_read(16'hF000, 8'h3F, 1, waits, addr);
        chk("rst_b3_addr", 32'(addr),         32'h00F000);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
